// File: rtl/tdc_patgen_pkg.sv
// Shared types and helpers for the TDC pattern generator.
// Holds pattern/index widths, mode encodings, the FSM state type and
// the index-to-pattern mapping (the inverse of the encoder's first-one finder).
package tdc_patgen_pkg;

   localparam int DIN_W     = 11;
   localparam int IDX_W     = 4;
   localparam int SWEEP_LEN = DIN_W + 1;   // every tap, then the all-zero pattern

   localparam logic [IDX_W-1:0] EXP_NONE = 4'hF;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_SWEEP  = 2'd1;
   localparam logic [1:0] MODE_RANDOM = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [DIN_W-1:0] pat;
      logic [IDX_W-1:0] exp;
   } pat_t;

   // Lowest set bit lands at k; bits above come from fill (thermometer) or
   // upper; indices past the last tap give an all-zero pattern.
   function automatic pat_t idx_to_pattern(input logic [IDX_W-1:0] k,
                                           input logic             fill,
                                           input logic [DIN_W-1:0] upper);
      pat_t r;
      r.pat = '0;
      r.exp = EXP_NONE;
      if (int'(k) < DIN_W) begin
         r.exp = k;
         for (int j = 0; j < DIN_W; j++) begin
            if (j == int'(k)) begin
               r.pat[j] = 1'b1;
            end else if (j > int'(k)) begin
               r.pat[j] = fill | upper[j];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tdc_pattern_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding random-mode patterns.
// Latency: new state visible the cycle after en_i.
// Backpressure: holds state whenever en_i is low.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q, state_d;

   // Shift left, feedback from taps 16,14,13,11 into bit 0.
   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
      end
   end

   // State register; reset only, never re-seeded between runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/tdc_pattern_gen.sv
// TDC encoder stimulus: single / sweep / random first-one patterns on a valid/ready stream.
// Latency: first dout_valid 2 cycles after start; one LOAD bubble between patterns.
// Backpressure: dout/dout_exp held while dout_valid & !dout_ready; LFSR frozen on stall.
// Random mode is built only with TDC_PATGEN_RANDOM_EN; otherwise mode 2 runs a sweep.
module tdc_pattern_gen
   import tdc_patgen_pkg::*;
#(
   parameter int unsigned N_RAND    = 64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [IDX_W-1:0] idx_in,
   input  logic             fill,
   input  logic [7:0]       rpt,
   output logic [DIN_W-1:0] dout,
   output logic [IDX_W-1:0] dout_exp,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             fill_q, fill_d;
   logic [7:0]       rpt_q, rpt_d;
   logic [7:0]       rcnt_q, rcnt_d;
   logic [7:0]       pcnt_q, pcnt_d;
   logic [DIN_W-1:0] dout_q, dout_d;
   logic [IDX_W-1:0] exp_q, exp_d;

   logic [IDX_W-1:0] cur_idx;
   logic [DIN_W-1:0] cur_upper;
   logic [7:0]       last_pcnt;
   pat_t             cur_pat;

`ifdef TDC_PATGEN_RANDOM_EN
   logic        lfsr_step;
   logic [15:0] lfsr_st;
   logic        lfsr_unused;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (lfsr_step),
      .state_o (lfsr_st)
   );

   assign lfsr_unused = lfsr_st[15];
`endif

   // Current pattern source and run length, chosen by the latched mode.
   always_comb begin
      cur_idx   = idx_q;
      cur_upper = '0;
      last_pcnt = 8'd0;
      if (mode_q == MODE_SWEEP) begin
         cur_idx   = pcnt_q[IDX_W-1:0];
         last_pcnt = 8'(SWEEP_LEN - 1);
      end
`ifdef TDC_PATGEN_RANDOM_EN
      else if (mode_q == MODE_RANDOM) begin
         cur_idx   = lfsr_st[IDX_W-1:0];
         cur_upper = lfsr_st[14:4];
         last_pcnt = 8'(N_RAND - 1);
      end
`endif
      cur_pat = idx_to_pattern(cur_idx, fill_q, cur_upper);
   end

   // Run FSM: latch request, load pattern, emit with repeats, pulse done.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      fill_d  = fill_q;
      rpt_d   = rpt_q;
      rcnt_d  = rcnt_q;
      pcnt_d  = pcnt_q;
      dout_d  = dout_q;
      exp_d   = exp_q;
`ifdef TDC_PATGEN_RANDOM_EN
      lfsr_step = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (mode)
                  MODE_SWEEP:  mode_d = MODE_SWEEP;
`ifdef TDC_PATGEN_RANDOM_EN
                  MODE_RANDOM: mode_d = MODE_RANDOM;
`else
                  MODE_RANDOM: mode_d = MODE_SWEEP;
`endif
                  default:     mode_d = MODE_SINGLE;
               endcase
               idx_d   = idx_in;
               fill_d  = fill;
               rpt_d   = rpt;
               rcnt_d  = 8'd0;
               pcnt_d  = 8'd0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            dout_d  = cur_pat.pat;
            exp_d   = cur_pat.exp;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (dout_ready) begin
               // Compare before increment so rpt=255 gives 256 copies without wrap.
               if (rcnt_q == rpt_q) begin
                  rcnt_d = 8'd0;
`ifdef TDC_PATGEN_RANDOM_EN
                  lfsr_step = (mode_q == MODE_RANDOM);
`endif
                  if (pcnt_q == last_pcnt) begin
                     state_d = ST_DONE;
                  end else begin
                     pcnt_d  = pcnt_q + 8'd1;
                     state_d = ST_LOAD;
                  end
               end else begin
                  rcnt_d = rcnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_SINGLE;
         idx_q   <= '0;
         fill_q  <= 1'b0;
         rpt_q   <= 8'd0;
         rcnt_q  <= 8'd0;
         pcnt_q  <= 8'd0;
         dout_q  <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         fill_q  <= fill_d;
         rpt_q   <= rpt_d;
         rcnt_q  <= rcnt_d;
         pcnt_q  <= pcnt_d;
         dout_q  <= dout_d;
         exp_q   <= exp_d;
      end
   end

   assign dout       = dout_q;
   assign dout_exp   = exp_q;
   assign dout_valid = (state_q == ST_EMIT);
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_EMIT);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_tdc_pattern_gen.sv
// Bench for tdc_pattern_gen: table-driven single-pattern vectors, sweeps with
// backpressure, long repeats, random runs against an LFSR reference, and
// mid-run reset. Expected patterns come from arithmetic on the index rules.
`timescale 1ns/1ps
module tb_tdc_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n, start, fill, dout_ready;
   logic [1:0]  mode;
   logic [3:0]  idx_in;
   logic [7:0]  rpt;
   logic [10:0] dout;
   logic [3:0]  dout_exp;
   logic        dout_valid, busy, done;

   always #5 clk = ~clk;

   tdc_pattern_gen #(.N_RAND(64), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .idx_in(idx_in),
      .fill(fill), .rpt(rpt), .dout(dout), .dout_exp(dout_exp),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
   );

   typedef struct packed { logic [10:0] d; logic [3:0] e; } xfer_t;
   typedef struct {
      logic [1:0] m; logic [3:0] k; logic f; logic [7:0] r;
      logic [10:0] d; logic [3:0] e;
   } vec_t;

   xfer_t       got[$];
   xfer_t       expq[$];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] lfsr_m;
   int          first_valid, stab_err;
   bit          finished, busy_early, done_clean, extra_done, idle_after;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Lowest set bit at k, bits above k from fill or upper, k>10 gives zero.
   function automatic xfer_t model_pat(input int k, input bit f, input logic [10:0] upper);
      xfer_t x;
      logic [10:0] above;
      if (k > 10) begin
         x.d = '0;
         x.e = 4'hF;
      end else begin
         above = 11'h7FF << (k + 1);
         x.d   = ((f ? 11'h7FF : upper) & above) | (11'h1 << k);
         x.e   = 4'(k);
      end
      return x;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      int   taps[4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      foreach (taps[i]) fb ^= s[taps[i]-1];
      return {s[14:0], fb};
   endfunction

   function automatic logic [3:0] lowbit(input logic [10:0] d);
      for (int j = 0; j < 11; j++) if (d[j]) return 4'(j);
      return 4'hF;
   endfunction

   task automatic exp_add(input int k, input bit f, input logic [10:0] up, input int reps);
      repeat (reps) expq.push_back(model_pat(k, f, up));
   endtask

   task automatic exp_sweep(input bit f, input int reps);
      for (int k = 0; k < 12; k++) exp_add(k, f, 11'h0, reps);
   endtask

   task automatic exp_random(input bit f, input int reps, input int n);
`ifdef TDC_PATGEN_RANDOM_EN
      for (int p = 0; p < n; p++) begin
         exp_add(int'(lfsr_m[3:0]), f, lfsr_m[14:4], reps);
         lfsr_m = lfsr_next(lfsr_m);
      end
`else
      if (n > 0) exp_sweep(f, reps);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; mode = 2'd0; idx_in = 4'd0;
      fill = 1'b0; rpt = 8'd0; dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      lfsr_m = 16'hACE1;
   endtask

   // One run; bp stalls 3 cycles on every odd pattern, hold keeps start high
   // through the DONE cycle, abort_after>=0 returns once that many transfers
   // completed and the next pattern is valid.
   task automatic run(input logic [1:0] m, input logic [3:0] k, input logic f,
                      input logic [7:0] r, input bit bp, input bit hold, input int abort_after);
      int          stall, stalled_for, pidx;
      bit          was_stall;
      logic [10:0] hd;
      logic [3:0]  he;
      got.delete();
      first_valid = -1; stab_err = 0; finished = 0; busy_early = 0;
      done_clean = 0; extra_done = 0; idle_after = 0;
      stall = 0; stalled_for = -1; was_stall = 0; hd = '0; he = '0;
      @(negedge clk);
      mode = m; idx_in = k; fill = f; rpt = r; dout_ready = 1'b1; start = 1'b1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         if (i == 1) busy_early = busy;
         if (abort_after >= 0 && got.size() == abort_after && dout_valid) return;
         if (dout_valid && first_valid < 0) first_valid = i;
         if (was_stall && !(dout_valid && dout == hd && dout_exp == he)) stab_err++;
         if (done) begin
            finished   = 1;
            done_clean = !busy && !dout_valid;
            break;
         end
         pidx = got.size() / (int'(r) + 1);
         if (bp && dout_valid && (pidx % 2 == 1) && stalled_for != pidx) begin
            stall = 3;
            stalled_for = pidx;
         end
         dout_ready = (stall == 0);
         if (stall > 0) stall--;
         was_stall = dout_valid && !dout_ready;
         hd = dout;
         he = dout_exp;
         if (dout_valid && dout_ready) got.push_back({dout, dout_exp});
      end
      @(negedge clk);
      start = 1'b0; dout_ready = 1'b1;
      extra_done = done;
      idle_after = !busy;
      @(negedge clk);
      idle_after = idle_after && !busy && !dout_valid && !done;
   endtask

   task automatic verify(input string tag);
      int n, lb_err;
      chk({tag, "_finished"}, 32'(finished), 32'd1);
      chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
      n = (got.size() < expq.size()) ? got.size() : expq.size();
      lb_err = 0;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_xfer%0d", tag, i), 32'(got[i]), 32'(expq[i]));
         if (lowbit(got[i].d) != got[i].e) lb_err++;
      end
      chk({tag, "_lowbit_rule"}, 32'(lb_err), 32'd0);
      chk({tag, "_first_valid_cycle"}, 32'(first_valid), 32'd2);
      chk({tag, "_busy_after_start"}, 32'(busy_early), 32'd1);
      chk({tag, "_done_cycle_outputs"}, 32'(done_clean), 32'd1);
      chk({tag, "_single_done_pulse"}, 32'(extra_done), 32'd0);
      chk({tag, "_idle_after_done"}, 32'(idle_after), 32'd1);
      chk({tag, "_stall_stable"}, 32'(stab_err), 32'd0);
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{2'd0, 4'd5,  1'b0, 8'd0, 11'h020, 4'h5};
      vt[1] = '{2'd0, 4'd13, 1'b0, 8'd0, 11'h000, 4'hF};
      vt[2] = '{2'd0, 4'd8,  1'b0, 8'd0, 11'h100, 4'h8};
      vt[3] = '{2'd0, 4'd0,  1'b1, 8'd0, 11'h7FF, 4'h0};
      vt[4] = '{2'd0, 4'd10, 1'b1, 8'd0, 11'h400, 4'hA};
      vt[5] = '{2'd3, 4'd3,  1'b1, 8'd0, 11'h7F8, 4'h3};
      vt[6] = '{2'd0, 4'd15, 1'b1, 8'd1, 11'h000, 4'hF};
      vt[7] = '{2'd0, 4'd2,  1'b0, 8'd3, 11'h004, 4'h2};

      // Reset state, checked both inside and after reset.
      rst_n = 1'b0; start = 1'b0; mode = 2'd0; idx_in = 4'd0;
      fill = 1'b0; rpt = 8'd0; dout_ready = 1'b0;
      #12;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_exp", 32'(dout_exp), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      do_reset();
      chk("post_rst_idle", 32'({dout_valid, busy, done}), 32'd0);

      // Single-pattern vectors.
      for (int v = 0; v < 8; v++) begin
         expq.delete();
         repeat (int'(vt[v].r) + 1) expq.push_back({vt[v].d, vt[v].e});
         run(vt[v].m, vt[v].k, vt[v].f, vt[v].r, 1'b0, 1'b0, -1);
         verify($sformatf("single%0d", v));
      end

      // Thermometer sweep; start held high through the run and the DONE cycle.
      expq.delete();
      exp_sweep(1'b1, 1);
      run(2'd1, 4'd7, 1'b1, 8'd0, 1'b0, 1'b1, -1);
      verify("sweep_therm");

      // Sweep with backpressure and three copies per pattern.
      expq.delete();
      exp_sweep(1'b0, 3);
      run(2'd1, 4'd0, 1'b0, 8'd2, 1'b1, 1'b0, -1);
      verify("sweep_bp");

      // Maximum repeat count.
      expq.delete();
      exp_add(1, 1'b0, 11'h0, 256);
      run(2'd0, 4'd1, 1'b0, 8'd255, 1'b0, 1'b0, -1);
      verify("rpt255");

      // Random runs from a fresh seed; the second continues the sequence.
      do_reset();
      expq.delete();
      exp_random(1'b0, 1, 64);
      run(2'd2, 4'($urandom_range(0, 15)), 1'b0, 8'd0, 1'b0, 1'b0, -1);
      verify("random");
      expq.delete();
      exp_random(1'b1, 2, 64);
      run(2'd2, 4'($urandom_range(0, 15)), 1'b1, 8'd1, 1'b1, 1'b0, -1);
      verify("random_cont");

      // Reset mid-run during sweep pattern 4.
      do_reset();
      run(2'd1, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4);
      chk("midrst_valid_before", 32'(dout_valid), 32'd1);
      chk("midrst_pat4", 32'({dout, dout_exp}), 32'(model_pat(4, 1'b0, 11'h0)));
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", 32'({dout, dout_exp, dout_valid, busy, done}), 32'd0);
      begin
         bit done_seen = 1'b0;
         repeat (3) begin
            @(negedge clk);
            done_seen |= done;
         end
         rst_n  = 1'b1;
         lfsr_m = 16'hACE1;
         repeat (2) begin
            @(negedge clk);
            done_seen |= done;
         end
         chk("midrst_no_done", 32'(done_seen), 32'd0);
      end
      expq.delete();
      exp_sweep(1'b0, 1);
      run(2'd1, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, -1);
      verify("after_midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
